// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, stall/done handshake to the pipeline.
// Define DIVIDER_SIGNED_EN to honour signed_op (sign fix-up logic); otherwise every operation is unsigned.
module iter_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] qw_q, qw_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] rmd_q, rmd_d;

  logic [DATA_W-1:0] dvd_mag, dvs_mag;
  logic [DATA_W:0]   rem_sh, trial;
  logic [DATA_W-1:0] rem_nx, qw_nx, q_fix, r_fix;

`ifdef DIVIDER_SIGNED_EN
  logic nq_q, nq_d, nr_q, nr_d;
  logic dvd_neg, dvs_neg;

  assign dvd_neg = signed_op & dividend[DATA_W-1];
  assign dvs_neg = signed_op & divisor[DATA_W-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;
  // Quotient negative when signs differ; remainder follows the dividend.
  assign q_fix   = nq_q ? -qw_nx : qw_nx;
  assign r_fix   = nr_q ? -rem_nx : rem_nx;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      nq_q <= 1'b0;
      nr_q <= 1'b0;
    end else begin
      nq_q <= nq_d;
      nr_q <= nr_d;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fix   = qw_nx;
  assign r_fix   = rem_nx;
`endif

  // One restoring step: shift {rem, q} left, trial-subtract, keep if non-negative.
  always_comb begin
    rem_sh = {rem_q, qw_q[DATA_W-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (!trial[DATA_W]) begin
      rem_nx = trial[DATA_W-1:0];
      qw_nx  = {qw_q[DATA_W-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[DATA_W-1:0];
      qw_nx  = {qw_q[DATA_W-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    qw_d    = qw_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
`ifdef DIVIDER_SIGNED_EN
    nq_d    = nq_q;
    nr_d    = nr_q;
`endif
    case (state_q)
      S_CALC: begin
        rem_d = rem_nx;
        qw_d  = qw_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          quot_d  = q_fix;
          rmd_d   = r_fix;
        end
      end
      default: begin
        // IDLE and DONE share the accept rules; DONE falls back to IDLE.
        state_d = S_IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rmd_d   = dividend;
          end else begin
            state_d = S_CALC;
            cnt_d   = CW'(DATA_W - 1);
            rem_d   = '0;
            qw_d    = dvd_mag;
            dvs_d   = dvs_mag;
`ifdef DIVIDER_SIGNED_EN
            nq_d    = dvd_neg ^ dvs_neg;
            nr_d    = dvd_neg;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      qw_q    <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      qw_q    <= qw_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
    end
  end

  assign stall     = (state_q == S_CALC) | (start & (state_q != S_CALC));
  assign done      = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = rmd_q;

endmodule
